mux4_rr_arbiter: RTL and testbench

Arbitration and sequencing controller for a shared 4:1 one-bit mux datapath. Four requesters (x0..x3 data, req[3:0]) compete for the single output f. The block grants one requester at a time in round-robin order, drives the mux selects {s1,s0}, and bounds each grant to MAX_HOLD cycles. It produces a registered f with a valid qualifier for downstream logic.

---
 rtl/mux4_arb_pkg.sv | 26 ++
 rtl/rr_pick4.sv | 55 +++++
 rtl/mux4_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the 4:1 mux round-robin arbiter.
//   state_e  : FSM encoding (ST_IDLE = 1'b0, ST_GRANT = 1'b1)
//   NREQ     : number of requesters
//   SELW     : mux select width
//   onehot2  : 2-bit index -> 4-bit one-hot grant vector
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot2(input logic [SELW-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage : mux4_arb_pkg

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational requester picker.
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : last served index; the scan starts at ptr+1 (mod 4)
//   found       out : at least one request is set
//   idx   [1:0] out : chosen requester index (0 when nothing is found)
// Build option: MUX4_ARB_FIXED_PRIO_EN selects fixed priority (index 0
// highest) and ignores ptr; otherwise the scan is circular round-robin.
// ---------------------------------------------------------------------------
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

`ifdef MUX4_ARB_FIXED_PRIO_EN
  // ptr is intentionally not consulted in the fixed-priority build.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = SELW'(i);
      end
    end
  end
`else
  logic [SELW-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // Natural 2-bit wrap gives the circular (ptr+i) mod 4 scan order.
      cand = ptr + SELW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`endif

endmodule : rr_pick4

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbitration and sequencing for a shared 4:1 one-bit mux.
// Grants one requester at a time, drives the mux selects, bounds every
// grant to MAX_HOLD cycles and registers the muxed bit with a valid flag.
//   clk          in  : rising-edge clock
//   rst_n        in  : asynchronous active-low reset
//   req   [3:0]  in  : request per requester (req[i] pairs with xi)
//   x0..x3       in  : requester data bits
//   gnt   [3:0]  out : registered one-hot grant, zero when idle
//   s1, s0       out : registered mux select (index of the granted requester)
//   busy         out : high while in the GRANT state
//   f            out : registered muxed data
//   f_valid      out : f carries a granted requester's data
// Build option: MUX4_ARB_FIXED_PRIO_EN (fixed priority, see rr_pick4).
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            x0,
  input  logic            x1,
  input  logic            x2,
  input  logic            x3,
  output logic [NREQ-1:0] gnt,
  output logic            s0,
  output logic            s1,
  output logic            busy,
  output logic            f,
  output logic            f_valid
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            f_q, f_d;
  logic            f_valid_q, f_valid_d;

  logic [NREQ-1:0] x_vec;
  logic [SELW-1:0] pick_ptr;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic            release_grant;

  assign x_vec = {x3, x2, x1, x0};

  // IDLE searches after the last served requester; a release searches
  // after the one currently holding the grant.
  assign pick_ptr = (state_q == ST_GRANT) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_grant = !req[sel_q] || (hold_q == HCW'(MAX_HOLD));

  // State register. last resets to 3 so the very first search begins at 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= SELW'(NREQ - 1);
      hold_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  // Next-state logic: grant selection and hold counting.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot2(pick_idx);
          hold_d  = HCW'(1);
        end else begin
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          last_d = sel_q;
          if (pick_found) begin
            // Back-to-back handover; may re-grant the same requester when
            // it is the only one still asking after hold expiry.
            sel_d  = pick_idx;
            gnt_d  = onehot2(pick_idx);
            hold_d = HCW'(1);
          end else begin
            // sel keeps its last value so the mux select stays stable.
            state_d = ST_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: one-cycle registered mux with a valid qualifier.
  always_comb begin
    busy_d    = (state_d == ST_GRANT);
    f_valid_d = (state_q == ST_GRANT) && req[sel_q];
    f_d       = f_valid_d ? x_vec[sel_q] : f_q;
  end

  assign gnt     = gnt_q;
  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
  assign busy    = busy_q;
  assign f       = f_q;
  assign f_valid = f_valid_q;

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD = 4).
// Inputs change 1 time unit after a rising edge and outputs are sampled
// at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       x0, x1, x2, x3;
  logic [3:0] gnt;
  logic       s0, s1, busy, f, f_valid;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .gnt     (gnt),
    .s0      (s0),
    .s1      (s1),
    .busy    (busy),
    .f       (f),
    .f_valid (f_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    {x3, x2, x1, x0} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Compare every observable output against an expected bundle.
  task automatic cmp_all(input string name, input logic [3:0] e_gnt,
                         input logic [1:0] e_sel, input logic e_busy,
                         input logic e_f, input logic e_fv);
    checks++;
    if ({gnt, s1, s0, busy, f, f_valid} !== {e_gnt, e_sel, e_busy, e_f, e_fv}) begin
      errors++;
      $display("FAIL %s: gnt=%b s=%b busy=%b f=%b fv=%b, expected gnt=%b s=%b busy=%b f=%b fv=%b",
               name, gnt, {s1, s0}, busy, f, f_valid, e_gnt, e_sel, e_busy, e_f, e_fv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    {x3, x2, x1, x0} = 4'b1111;
    #3;
    cmp_all("reset_asserted", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cmp_all($sformatf("reset_idle_%0d", k), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req = 4'b0100;
    x2  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp_all($sformatf("single_%0d", k), 4'b0100, 2'b10, 1'b1,
              (k >= 1), (k >= 1));
    end
    req = 4'b0000;
  endtask

  task automatic test_all_requesting();
    logic [1:0] e_idx;
    do_reset();
    req = 4'b1111;
    {x3, x2, x1, x0} = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      tick();
      e_idx = FIXED ? 2'd0 : 2'((k / 4) % 4);
      checks++;
      if ({gnt, s1, s0, busy} !== {4'b0001 << e_idx, e_idx, 1'b1}) begin
        errors++;
        $display("FAIL all_req_%0d: gnt=%b s=%b busy=%b, expected gnt=%b s=%b busy=1",
                 k, gnt, {s1, s0}, busy, 4'b0001 << e_idx, e_idx);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_early_drop();
    logic [3:0] e_next;
    logic [1:0] e_sel;
    do_reset();
    e_next = FIXED ? 4'b0001 : 4'b1000;
    e_sel  = FIXED ? 2'd0 : 2'd3;
    req = 4'b0010;
    {x3, x2, x1, x0} = 4'b0010;
    tick();
    cmp_all("drop_grant1_a", 4'b0010, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    cmp_all("drop_grant1_b", 4'b0010, 2'b01, 1'b1, 1'b1, 1'b1);
    req = 4'b1001;
    tick();
    cmp_all("drop_handover", e_next, e_sel, 1'b1, 1'b1, 1'b0);
    tick();
    cmp_all("drop_new_data", e_next, e_sel, 1'b1, 1'b0, 1'b1);
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0100;
    x2  = 1'b1;
    tick();
    cmp_all("b2b_grant2", 4'b0100, 2'b10, 1'b1, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    cmp_all("b2b_to_idle", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    // last is now 2: the round-robin scan starts at 3 and wraps to 0.
    req = 4'b0101;
    x0  = 1'b1;
    tick();
    cmp_all("b2b_wrap_grant0", 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    cmp_all("b2b_wrap_data", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b1);
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    x1  = 1'b1;
    tick();
    tick();
    cmp_all("arst_pre", 4'b0010, 2'b01, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_all("arst_immediate", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    req = 4'b1110;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cmp_all("arst_first_grant", 4'b0010, 2'b01, 1'b1, 1'b0, 1'b0);
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_all_requesting();
    test_early_drop();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux4_rr_arbiter
